execute_load_return: RTL and testbench

Return-path companion to the execute-stage load/store address calculator. It records the order, byte shift, destination and direction of every LDST request issued to the LDST pipe, then matches in-order memory responses to those records. Load data is extracted and zero-extended into a register-ready word, and a completion is presented to writeback through a one-entry registered output stage. It sits between the LDST pipe response bus and the writeback stage, and supports pipeline flush with outstanding responses still in flight.

---
 rtl/execute_load_return_pkg.sv | 25 ++
 rtl/execute_load_return_fifo.sv | 46 ++++
 rtl/execute_load_return.sv | 110 +++++++++++
 tb/tb_execute_load_return.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/execute_load_return_pkg.sv
// execute_load_return_pkg: request encodings shared by the LDST address calculator and return path.
package execute_load_return_pkg;

    typedef enum logic [1:0] {
        ORDER_BYTE = 2'd0,
        ORDER_HALF = 2'd1,
        ORDER_WORD = 2'd2,
        ORDER_RSVD = 2'd3
    } order_e;

    typedef enum logic {
        RW_LOAD  = 1'b0,
        RW_STORE = 1'b1
    } rw_e;

    typedef struct packed {
        rw_e        rw;
        order_e     order;
        logic [1:0] shift;
        logic [4:0] destination;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/execute_load_return_fifo.sv
// execute_load_return_fifo: synchronous FIFO with occupancy count and pointer-clearing flush.
module execute_load_return_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [DEPTH_N:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0] count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_N'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_N'(pop);
        count_d  = flush ? '0 : count_q + (DEPTH_N+1)'(push) - (DEPTH_N+1)'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/execute_load_return.sv
// execute_load_return: matches in-order LDST responses to tracked requests and
// presents aligned completions to writeback through a one-entry output stage.
module execute_load_return
    import execute_load_return_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iREQ_VALID,
    output logic        oREQ_BUSY,
    input  logic        iREQ_RW,
    input  logic [1:0]  iREQ_ORDER,
    input  logic [1:0]  iREQ_SHIFT,
    input  logic [4:0]  iREQ_DESTINATION,
    input  logic        iMEM_VALID,
    output logic        oMEM_BUSY,
    input  logic [31:0] iMEM_DATA,
    output logic        oWB_VALID,
    input  logic        iWB_BUSY,
    output logic        oWB_WRITE,
    output logic [4:0]  oWB_DESTINATION,
    output logic [31:0] oWB_DATA,
    output logic        oEMPTY,
    output logic        oERROR
);

    function automatic logic [31:0] align(req_t r, logic [31:0] d);
        if (r.rw == RW_STORE) return '0;
        case (r.order)
            ORDER_BYTE: return {24'b0, 8'(d >> {r.shift, 3'b000})};
            ORDER_HALF: return (r.shift == 2'd0) ? {16'b0, d[15:0]} :
                               (r.shift == 2'd2) ? {16'b0, d[31:16]} : '0;
            ORDER_WORD: return d;
            default:    return '0;
        endcase
    endfunction

    logic [REQ_W-1:0] head_bits;
    req_t head;
    logic [P_DEPTH_N:0] count, discard_q, discard_d;
    logic [P_DEPTH_N+1:0] occupancy;
    logic push, pop, accept, drop, hold, load;
    logic error_q, error_d;
    logic wb_valid_q, wb_valid_d, wb_write_q, wb_write_d;
    logic [4:0] wb_dest_q, wb_dest_d;
    logic [31:0] wb_data_q, wb_data_d;

    execute_load_return_fifo #(
        .WIDTH(REQ_W), .DEPTH(DEPTH), .DEPTH_N(P_DEPTH_N)
    ) u_fifo (
        .clk   (iCLOCK),
        .rst   (iRESET_SYNC),
        .flush (iFLUSH),
        .push  (push),
        .pop   (pop),
        .wdata ({iREQ_RW, iREQ_ORDER, iREQ_SHIFT, iREQ_DESTINATION}),
        .rdata (head_bits),
        .count (count)
    );

    assign head      = req_t'(head_bits);
    assign occupancy = {1'b0, count} + {1'b0, discard_q};
    assign oREQ_BUSY = occupancy >= (P_DEPTH_N+2)'(DEPTH);
    assign oMEM_BUSY = wb_valid_q && iWB_BUSY;
    assign oEMPTY    = (count == '0) && (discard_q == '0);
    assign oERROR    = error_q;
    assign oWB_VALID = wb_valid_q;
    assign oWB_WRITE = wb_write_q;
    assign oWB_DESTINATION = wb_dest_q;
    assign oWB_DATA  = wb_data_q;

    // Discarded responses take priority over live entries so a flushed load never reaches writeback.
    always_comb begin
        accept    = iMEM_VALID && !oMEM_BUSY;
        drop      = accept && (discard_q != '0);
        pop       = accept && (discard_q == '0) && (count != '0);
        push      = iREQ_VALID && !oREQ_BUSY && !iFLUSH;
        discard_d = iFLUSH ? discard_q + count - (P_DEPTH_N+1)'(drop || pop)
                           : discard_q - (P_DEPTH_N+1)'(drop);
        error_d   = error_q || (accept && (discard_q == '0) && (count == '0));
        hold      = wb_valid_q && iWB_BUSY;
        load      = pop && !iFLUSH;
        wb_valid_d = !iFLUSH && (load || hold);
        wb_write_d = iFLUSH ? 1'b0 : load ? (head.rw == RW_LOAD) : hold && wb_write_q;
        wb_dest_d  = iFLUSH ? '0 : load ? head.destination : hold ? wb_dest_q : '0;
        wb_data_d  = iFLUSH ? '0 : load ? align(head, iMEM_DATA) : hold ? wb_data_q : '0;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            discard_q  <= '0;
            error_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_write_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            discard_q  <= discard_d;
            error_q    <= error_d;
            wb_valid_q <= wb_valid_d;
            wb_write_q <= wb_write_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_execute_load_return.sv
// tb_execute_load_return: directed scenarios plus random traffic against a queue-based reference model.
module tb_execute_load_return;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_rw, mem_valid, wb_busy;
    logic [1:0]  req_order, req_shift;
    logic [4:0]  req_dest;
    logic [31:0] mem_data;
    logic        req_busy, mem_busy, wb_valid, wb_write, empty, error;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit       rw;
        bit [1:0] ord;
        bit [1:0] sh;
        bit [4:0] dst;
    } ent_t;

    ent_t        q[$];
    int          disc;
    bit          m_err, m_valid, m_write;
    bit [4:0]    m_dest;
    bit [31:0]   m_data;

    execute_load_return dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
        .iREQ_VALID(req_valid), .oREQ_BUSY(req_busy), .iREQ_RW(req_rw),
        .iREQ_ORDER(req_order), .iREQ_SHIFT(req_shift), .iREQ_DESTINATION(req_dest),
        .iMEM_VALID(mem_valid), .oMEM_BUSY(mem_busy), .iMEM_DATA(mem_data),
        .oWB_VALID(wb_valid), .iWB_BUSY(wb_busy), .oWB_WRITE(wb_write),
        .oWB_DESTINATION(wb_dest), .oWB_DATA(wb_data), .oEMPTY(empty), .oERROR(error)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] extract(ent_t e, bit [31:0] d);
        if (e.rw) return 0;
        if (e.ord == 0) return (d >> (8 * e.sh)) & 32'hFF;
        if (e.ord == 1) return (e.sh == 0) ? (d & 32'hFFFF) : (e.sh == 2) ? (d >> 16) : 0;
        if (e.ord == 2) return d;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("empty", 32'(empty), 32'((q.size() == 0) && (disc == 0)));
        chk("error", 32'(error), 32'(m_err));
        chk("req_busy", 32'(req_busy), 32'((q.size() + disc) >= 4));
        chk("mem_busy", 32'(mem_busy), 32'(m_valid && wb_busy));
        if (m_valid) begin
            chk("wb_write", 32'(wb_write), 32'(m_write));
            chk("wb_data", wb_data, m_data);
            if (m_write) chk("wb_dest", 32'(wb_dest), 32'(m_dest));
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, advances the model, checks at the next falling edge.
    task automatic step(input bit rv, input bit rw, input bit [1:0] ord, input bit [1:0] sh,
                        input bit [4:0] dst, input bit mv, input bit [31:0] md,
                        input bit wbb, input bit fl);
        bit rb, mb, acc, popped;
        ent_t e;
        req_valid = rv; req_rw = rw; req_order = ord; req_shift = sh; req_dest = dst;
        mem_valid = mv; mem_data = md; wb_busy = wbb; flush = fl;
        rb = (q.size() + disc) >= 4;
        mb = m_valid && wbb;
        acc = mv && !mb;
        popped = 0;
        if (acc) begin
            if (disc > 0) disc--;
            else if (q.size() > 0) begin e = q.pop_front(); popped = 1; end
            else m_err = 1;
        end
        if (fl) begin
            m_valid = 0; m_write = 0; m_dest = 0; m_data = 0;
            disc += q.size();
            q.delete();
        end else if (popped) begin
            m_valid = 1; m_write = !e.rw; m_dest = e.dst; m_data = extract(e, md);
        end else if (!mb) begin
            m_valid = 0; m_write = 0; m_dest = 0; m_data = 0;
        end
        if (rv && !rb && !fl) q.push_back('{rw, ord, sh, dst});
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_req(input bit rw, input bit [1:0] ord, input bit [1:0] sh, input bit [4:0] dst);
        step(1, rw, ord, sh, dst, 0, 0, 0, 0);
    endtask

    task automatic resp(input bit [31:0] d, input bit wbb);
        step(0, 0, 0, 0, 0, 1, d, wbb, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; flush = 0; req_valid = 0; req_rw = 0; req_order = 0; req_shift = 0;
        req_dest = 0; mem_valid = 0; mem_data = 0; wb_busy = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        q.delete(); disc = 0; m_err = 0; m_valid = 0; m_write = 0; m_dest = 0; m_data = 0;
        compare_all();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_write", 32'(wb_write), 0);
        chk("rst_wb_dest", 32'(wb_dest), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_req_busy", 32'(req_busy), 0);
        chk("rst_mem_busy", 32'(mem_busy), 0);
    endtask

    initial begin
        rst = 1;
        do_reset();

        push_req(0, 0, 3, 7);
        resp(32'hAABBCCDD, 0);
        chk("byte_valid", 32'(wb_valid), 1);
        chk("byte_write", 32'(wb_write), 1);
        chk("byte_dest", 32'(wb_dest), 7);
        chk("byte_data", wb_data, 32'h000000AA);

        push_req(0, 1, 2, 3);
        push_req(0, 1, 0, 4);
        resp(32'h12345678, 0);
        chk("half_hi", wb_data, 32'h00001234);
        resp(32'h12345678, 0);
        chk("half_lo", wb_data, 32'h00005678);
        chk("half_lo_dest", 32'(wb_dest), 4);
        idle(1);

        for (int i = 0; i < 4; i++) push_req(0, 2, 0, 5'(10 + i));
        chk("full_busy", 32'(req_busy), 1);
        step(1, 0, 2, 0, 9, 1, 32'h11223344, 0, 0);
        chk("full_pop_data", wb_data, 32'h11223344);
        chk("full_busy_drop", 32'(req_busy), 0);
        for (int i = 0; i < 3; i++) resp($urandom, 0);
        idle(1);
        chk("full_empty", 32'(empty), 1);

        push_req(0, 2, 0, 1);
        push_req(0, 2, 0, 2);
        resp(32'hCAFE0001, 1);
        for (int i = 0; i < 3; i++) begin
            resp(32'hCAFE0002, 1);
            chk("stall_mem_busy", 32'(mem_busy), 1);
            chk("stall_data", wb_data, 32'hCAFE0001);
        end
        resp(32'hCAFE0002, 0);
        chk("stall_release_data", wb_data, 32'hCAFE0002);
        chk("stall_release_dest", 32'(wb_dest), 2);
        idle(1);

        for (int i = 0; i < 3; i++) push_req(0, 2, 0, 5'(20 + i));
        step(0, 0, 0, 0, 0, 1, 32'h0BAD0001, 0, 1);
        chk("flush_valid", 32'(wb_valid), 0);
        chk("flush_empty", 32'(empty), 0);
        for (int i = 0; i < 2; i++) begin
            resp(32'h0BAD0002, 0);
            chk("flush_dropped", 32'(wb_valid), 0);
        end
        chk("flush_drained", 32'(empty), 1);
        push_req(0, 2, 0, 30);
        resp(32'h600DF00D, 0);
        chk("flush_after_data", wb_data, 32'h600DF00D);
        idle(1);
        chk("flush_final_empty", 32'(empty), 1);

        resp(32'hDEADBEEF, 0);
        chk("spur_valid", 32'(wb_valid), 0);
        chk("spur_error", 32'(error), 1);
        idle(3);
        chk("spur_sticky", 32'(error), 1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1), 1'($urandom), 2'($urandom), 2'($urandom),
                 5'($urandom), ($urandom_range(0, 9) < 4), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
            if (i == 1500) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
